// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the parameterised register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: sweeps every address writing zero, then raises ready.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we,
    output logic              ready
);

    state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            clr_we   <= 1'b1;
            ready    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                    // Last address is being cleared on this edge: hand over to users.
                    if (&clr_addr) begin
                        state  <= IDLE;
                        clr_we <= 1'b0;
                        ready  <= 1'b1;
                    end
                end
                IDLE: begin
                    clr_we <= 1'b0;
                    ready  <= 1'b1;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: rtl/param_register_file.sv
// Two-read, one-write register file with byte-masked writes, optional
// write-to-read forwarding and optional hardwired-zero register 0.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [ADDR_W-1:0]   read_reg1,
    input  logic [ADDR_W-1:0]   read_reg2,
    input  logic [ADDR_W-1:0]   write_reg,
    input  logic [DATA_W-1:0]   write_data,
    input  logic                regWrite,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   read_data1,
    output logic [DATA_W-1:0]   read_data2,
    output logic                ready
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;
    logic              access_ok;
    logic              user_we;
    logic [DATA_W-1:0] wr_merged;
    logic              hit1;
    logic              hit2;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (CLK),
        .rst      (RST),
        .clr_addr (clr_addr),
        .clr_we   (clr_we),
        .ready    (ready)
    );

    // RST gates access immediately, before the registered ready has fallen.
    assign access_ok = ready && !RST;
    assign user_we   = access_ok && regWrite &&
                       !(ZERO_REG && (write_reg == ADDR_W'(0)));

    always_comb begin
        wr_merged = mem[write_reg];
        for (int b = 0; b < NBYTES; b++) begin
            if (byte_en[b]) begin
                wr_merged[8*b +: 8] = write_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (user_we) begin
            mem[write_reg] <= wr_merged;
        end
    end

    assign hit1 = BYPASS && user_we && (read_reg1 == write_reg);
    assign hit2 = BYPASS && user_we && (read_reg2 == write_reg);

    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (access_ok) begin
            read_data1 = hit1 ? wr_merged : mem[read_reg1];
            read_data2 = hit2 ? wr_merged : mem[read_reg2];
            if (ZERO_REG && (read_reg1 == ADDR_W'(0))) begin
                read_data1 = '0;
            end
            if (ZERO_REG && (read_reg2 == ADDR_W'(0))) begin
                read_data2 = '0;
            end
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// Directed, table-driven bench for param_register_file (bypass, no-bypass and 64-bit instances).
module tb_param_register_file;

    logic        CLK;
    logic        RST;

    logic [4:0]  rr1, rr2, wreg;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_ready, b_ready;

    logic [2:0]  c_rr1, c_rr2, c_wreg;
    logic [63:0] c_wdata;
    logic        c_we;
    logic [7:0]  c_be;
    logic [63:0] c_rd1, c_rd2;
    logic        c_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] b1;
        logic [31:0] b2;
    } vec_t;

    vec_t vecs [11];

    param_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_a (
        .CLK(CLK), .RST(RST), .read_reg1(rr1), .read_reg2(rr2), .write_reg(wreg),
        .write_data(wdata), .regWrite(we), .byte_en(be),
        .read_data1(a_rd1), .read_data2(a_rd2), .ready(a_ready)
    );

    param_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_b (
        .CLK(CLK), .RST(RST), .read_reg1(rr1), .read_reg2(rr2), .write_reg(wreg),
        .write_data(wdata), .regWrite(we), .byte_en(be),
        .read_data1(b_rd1), .read_data2(b_rd2), .ready(b_ready)
    );

    param_register_file #(.DATA_W(64), .ADDR_W(3), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_c (
        .CLK(CLK), .RST(RST), .read_reg1(c_rr1), .read_reg2(c_rr2), .write_reg(c_wreg),
        .write_data(c_wdata), .regWrite(c_we), .byte_en(c_be),
        .read_data1(c_rd1), .read_data2(c_rd2), .ready(c_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a_k, b_k, c_k, k;

        vecs[0]  = '{1'b1, 5'd20, 32'h20000003, 4'hF, 5'd20, 5'd0,  32'h20000003, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd20, 5'd20, 32'h20000003, 32'h20000003, 32'h20000003, 32'h20000003};
        vecs[2]  = '{1'b1, 5'd25, 32'h3000000F, 4'hF, 5'd25, 5'd20, 32'h3000000F, 32'h20000003, 32'h0,        32'h20000003};
        vecs[3]  = '{1'b1, 5'd25, 32'hAABBCCDD, 4'h5, 5'd25, 5'd25, 32'h30BB00DD, 32'h30BB00DD, 32'h3000000F, 32'h3000000F};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd25, 5'd1,  32'h30BB00DD, 32'h0,        32'h30BB00DD, 32'h0};
        vecs[5]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd0,  5'd20, 32'h0,        32'h20000003, 32'h0,        32'h20000003};
        vecs[7]  = '{1'b1, 5'd20, 32'h12345678, 4'h0, 5'd20, 5'd20, 32'h20000003, 32'h20000003, 32'h20000003, 32'h20000003};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd20, 5'd25, 32'h20000003, 32'h30BB00DD, 32'h20000003, 32'h30BB00DD};
        vecs[9]  = '{1'b1, 5'd31, 32'hCAFEBABE, 4'h8, 5'd31, 5'd30, 32'hCA000000, 32'h0,        32'h0,        32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd31, 5'd31, 32'hCA000000, 32'hCA000000, 32'hCA000000, 32'hCA000000};

        RST = 1'b1;
        rr1 = '0; rr2 = '0; wreg = '0; wdata = '0; we = 1'b0; be = '0;
        c_rr1 = '0; c_rr2 = '0; c_wreg = '0; c_wdata = '0; c_we = 1'b0; c_be = '0;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst a_ready", 64'(a_ready), 64'd0);
        chk("rst b_ready", 64'(b_ready), 64'd0);
        chk("rst c_ready", 64'(c_ready), 64'd0);
        chk("rst a_rd1", 64'(a_rd1), 64'd0);

        // Release and measure clear latency of each instance
        RST = 1'b0;
        a_k = 0; b_k = 0; c_k = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge CLK); #1;
            if (a_k == 0 && a_ready) a_k = i;
            if (b_k == 0 && b_ready) b_k = i;
            if (c_k == 0 && c_ready) c_k = i;
            if (a_k != 0 && b_k != 0 && c_k != 0) break;
        end
        chk("clear latency a", 64'(a_k), 64'd32);
        chk("clear latency b", 64'(b_k), 64'd32);
        chk("clear latency c", 64'(c_k), 64'd8);

        // Every register reads zero after the clear
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            rr1 = 5'(i); rr2 = 5'(31 - i);
            #1;
            chk($sformatf("clr a reg%0d", i), 64'(a_rd1), 64'd0);
            chk($sformatf("clr b reg%0d", 31 - i), 64'(b_rd2), 64'd0);
        end

        // Table-driven write/read vectors
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            we = vecs[i].wr; wreg = vecs[i].waddr; wdata = vecs[i].wdata; be = vecs[i].be;
            rr1 = vecs[i].r1; rr2 = vecs[i].r2;
            #1;
            chk($sformatf("row%0d a_rd1", i), 64'(a_rd1), 64'(vecs[i].a1));
            chk($sformatf("row%0d a_rd2", i), 64'(a_rd2), 64'(vecs[i].a2));
            chk($sformatf("row%0d b_rd1", i), 64'(b_rd1), 64'(vecs[i].b1));
            chk($sformatf("row%0d b_rd2", i), 64'(b_rd2), 64'(vecs[i].b2));
        end
        @(negedge CLK);
        we = 1'b0;

        // 64-bit instance: byte merge on reg 7
        c_we = 1'b1; c_wreg = 3'd7; c_wdata = 64'h0123456789ABCDEF; c_be = 8'hFF;
        c_rr1 = 3'd7; c_rr2 = 3'd0;
        #1;
        chk("c full wr bypass", c_rd1, 64'h0123456789ABCDEF);
        @(negedge CLK);
        c_wdata = 64'hFFEEDDCCBBAA9988; c_be = 8'b1010_0101; c_rr2 = 3'd7;
        #1;
        chk("c merge bypass p1", c_rd1, 64'hFF23DD6789AACD88);
        chk("c merge bypass p2", c_rd2, 64'hFF23DD6789AACD88);
        @(negedge CLK);
        c_we = 1'b0; c_rr1 = 3'd7; c_rr2 = 3'd0;
        #1;
        chk("c merge stored", c_rd1, 64'hFF23DD6789AACD88);
        chk("c reg0", c_rd2, 64'd0);

        // Reset from IDLE: reads gate off immediately, ready drops on the next edge
        @(negedge CLK);
        rr1 = 5'd20; rr2 = 5'd25;
        #1;
        chk("pre-rst reg20", 64'(a_rd1), 64'h20000003);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst read gated", 64'(a_rd1), 64'd0);
        @(posedge CLK); #1;
        chk("rst ready drop", 64'(a_ready), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Ten clear cycles with writes that must be dropped, then reset mid-clear
        we = 1'b1; wreg = 5'd5; wdata = 32'hDEADBEEF; be = 4'hF; rr1 = 5'd5;
        repeat (10) @(posedge CLK);
        #1;
        chk("midclear ready", 64'(a_ready), 64'd0);
        chk("midclear read", 64'(a_rd1), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge CLK); #1;
            if (i == 20) we = 1'b0;
            if (a_ready) begin
                k = i;
                break;
            end
        end
        chk("restart latency", 64'(k), 64'd32);

        @(negedge CLK);
        rr1 = 5'd5; rr2 = 5'd20;
        #1;
        chk("dropped write reg5", 64'(a_rd1), 64'd0);
        chk("recleared reg20", 64'(a_rd2), 64'd0);
        @(negedge CLK);
        rr1 = 5'd25; rr2 = 5'd31;
        #1;
        chk("recleared reg25", 64'(b_rd1), 64'd0);
        chk("recleared reg31", 64'(b_rd2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
